// File: rtl/cordic_arb_pkg.sv
// cordic_arb_pkg -- shared types and constants for the cordic_arbiter slice.
//   arb_state_e        : arbiter FSM states (IDLE, CRST, LAUNCH, WAIT, RESP)
//   arb_resp_t         : registered response payload (sin, cos, err)
//   FLOAT_QNAN         : IEEE-754 single quiet NaN returned on a watchdog expiry
//   TIMEOUT_CYCLES_DEF : default WAIT watchdog limit
package cordic_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CRST   = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } arb_state_e;

  typedef struct packed {
    logic [31:0] sin_f;
    logic [31:0] cos_f;
    logic        err;
  } arb_resp_t;

  localparam logic [31:0] FLOAT_QNAN         = 32'h7FC00000;
  localparam int          TIMEOUT_CYCLES_DEF = 256;

endpackage

// File: rtl/cordic_rr_pick.sv
// cordic_rr_pick -- combinational round-robin picker.
// Scans the request vector starting at ptr and wrapping, and returns the
// first requester found.
//   req     : per-requester request vector
//   ptr     : highest-priority index for this arbitration
//   gnt     : one-hot grant (all zero when nothing is requesting)
//   idx     : binary index of the granted requester
//   any_req : at least one request present
module cordic_rr_pick
  import cordic_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any_req
);

  logic [ID_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int off = 0; off < N_REQ; off++) begin
      // modulo keeps the scan inside 0..N_REQ-1 for non-power-of-two N_REQ
      cand = ID_W'((int'(ptr) + off) % N_REQ);
      if (!any_req && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        any_req   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// cordic_arbiter -- time-shares a single cordic_top core between N_REQ
// clients with round-robin arbitration. Each operation: accept a request,
// reset the core for one cycle, launch the angle, wait for done, and strobe
// the sin/cos result back to the requester that was granted.
//
// Optional build macro: CORDIC_ARB_TIMEOUT_EN -- adds a WAIT watchdog that
// answers with resp_err=1 and qNaN results after TIMEOUT_CYCLES cycles
// without done. Without it, WAIT waits forever and resp_err stays 0.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/angle   : per-requester level request + IEEE-754 angle (deg),
//                       angle slice i = req_angle[32*i+31:32*i]
//   req_ready         : one-hot, single-cycle accept pulse
//   resp_valid        : one-hot, single-cycle result strobe
//   resp_id/sin/cos   : answered requester and its results (held until next)
//   resp_err          : result invalid (watchdog expiry)
//   busy              : arbiter is not IDLE
//   cordic_*          : interface to the shared core
module cordic_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int ID_W           = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [32*N_REQ-1:0]   req_angle,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_sin,
  output logic [31:0]           resp_cos,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  cordic_rst,
  output logic                  cordic_valid_in,
  output logic [31:0]           cordic_angle,
  input  logic [31:0]           cordic_sin,
  input  logic [31:0]           cordic_cos,
  input  logic                  cordic_done
);

  logic [N_REQ-1:0][31:0] angle_arr;
  assign angle_arr = req_angle;

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  arb_resp_t        resp_q, resp_d;
  logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [31:0]      angle_q, angle_d;
  logic             valid_in_q, valid_in_d;
  logic             busy_q, busy_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic             timeout_hit;

  cordic_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Held at zero outside WAIT, so the first WAIT cycle always sees 0.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == WAIT) to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end

  assign timeout_hit = (state_q == WAIT) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
`else
  // No watchdog in this build; the limit is unused here.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    resp_id_d    = resp_id_q;
    resp_d       = resp_q;
    angle_d      = angle_q;
    resp_valid_d = '0;
    valid_in_d   = 1'b0;
    req_ready    = '0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          // accept pulse is a decode of the grant so the client sees it in
          // the same cycle the FSM commits; masked while reset is applied
          req_ready  = rst ? '0 : pick_gnt;
          resp_id_d  = pick_idx;
          angle_d    = angle_arr[pick_idx];
          resp_d.err = 1'b0;
          state_d    = CRST;
        end
      end
      CRST: begin
        valid_in_d = 1'b1;
        state_d    = LAUNCH;
      end
      LAUNCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        // done takes priority over a watchdog expiry in the same cycle
        if (cordic_done) begin
          resp_d.sin_f            = cordic_sin;
          resp_d.cos_f            = cordic_cos;
          resp_d.err              = 1'b0;
          resp_valid_d[resp_id_q] = 1'b1;
          state_d                 = RESP;
        end else if (timeout_hit) begin
          resp_d.sin_f            = FLOAT_QNAN;
          resp_d.cos_f            = FLOAT_QNAN;
          resp_d.err              = 1'b1;
          resp_valid_d[resp_id_q] = 1'b1;
          state_d                 = RESP;
        end
      end
      RESP: begin
        // the requester just served drops to lowest priority
        ptr_d   = (resp_id_q == ID_W'(N_REQ - 1)) ? '0 : resp_id_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      resp_id_q    <= '0;
      resp_q       <= '0;
      resp_valid_q <= '0;
      angle_q      <= '0;
      valid_in_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      resp_id_q    <= resp_id_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
      angle_q      <= angle_d;
      valid_in_q   <= valid_in_d;
      busy_q       <= busy_d;
    end
  end

  assign resp_valid      = resp_valid_q;
  assign resp_id         = resp_id_q;
  assign resp_sin        = resp_q.sin_f;
  assign resp_cos        = resp_q.cos_f;
  assign resp_err        = resp_q.err;
  assign busy            = busy_q;
  assign cordic_valid_in = valid_in_q;
  assign cordic_angle    = angle_q;
  // core reset also covers a mid-operation abort through rst
  assign cordic_rst      = rst | (state_q == CRST);

endmodule

// File: tb/tb_cordic_arbiter.sv
module tb_cordic_arbiter;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] s;
    logic [31:0] c;
    logic        e;
  } exp_t;

  localparam logic [31:0] ANG [4] = '{32'h00000000, 32'h41F00000, 32'h42700000, 32'h42B40000};
  localparam logic [31:0] SIN [4] = '{32'h00000000, 32'h3F000000, 32'h3F5DB3D7, 32'h3F800000};
  localparam logic [31:0] COS [4] = '{32'h3F800000, 32'h3F5DB3D7, 32'h3F000000, 32'h00000000};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_angle = '0;
  logic [3:0]   req_ready, resp_valid;
  logic [1:0]   resp_id;
  logic [31:0]  resp_sin, resp_cos, cordic_angle;
  logic         resp_err, busy, cordic_rst, cordic_valid_in, cordic_done;

  // behavioural core
  logic [31:0]  m_sin = '0, m_cos = '0;
  logic         done_m = 1'b0, pend = 1'b0, inj_done = 1'b0, hang = 1'b0;
  int           m_cnt = 0, lat = 20;
  int           cyc = 0;
  int           n_cmp = 0, n_bad = 0;
  exp_t         exp_q[$];

  assign cordic_done = done_m | inj_done;

  cordic_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_angle(req_angle),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_sin(resp_sin), .resp_cos(resp_cos), .resp_err(resp_err), .busy(busy),
    .cordic_rst(cordic_rst), .cordic_valid_in(cordic_valid_in),
    .cordic_angle(cordic_angle), .cordic_sin(m_sin), .cordic_cos(m_cos),
    .cordic_done(cordic_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_sc(input logic [31:0] a);
    case (a)
      32'h00000000: return {32'h00000000, 32'h3F800000};
      32'h41F00000: return {32'h3F000000, 32'h3F5DB3D7};
      32'h42700000: return {32'h3F5DB3D7, 32'h3F000000};
      32'h42B40000: return {32'h3F800000, 32'h00000000};
      default:      return {a ^ 32'h5A5A5A5A, ~a};
    endcase
  endfunction

  always @(posedge clk) begin
    done_m <= 1'b0;
    if (cordic_rst) begin
      pend <= 1'b0;
    end else if (cordic_valid_in) begin
      pend  <= 1'b1;
      m_cnt <= lat;
      {m_sin, m_cos} <= ref_sc(cordic_angle);
    end else if (pend) begin
      if (m_cnt <= 1) begin
        pend   <= 1'b0;
        done_m <= !hang;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Called at a negedge; returns at the negedge (+1) where req_ready is seen.
  task automatic wait_ready(output logic [3:0] r, output int t, output bit ok);
    ok = 1'b0; r = '0; t = -1;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (req_ready !== 4'b0) begin r = req_ready; t = cyc; ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Observes (does not judge) the next response and the last done before it.
  task automatic wait_resp(output logic [3:0] rv, output exp_t obs, output int rc,
                           output int dc, output bit ok);
    ok = 1'b0; rv = '0; obs = '0; rc = -1; dc = -100;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (resp_valid !== 4'b0) begin
        rv = resp_valid; obs = {resp_id, resp_sin, resp_cos, resp_err};
        rc = cyc; ok = 1'b1; break;
      end
      if (cordic_done === 1'b1) dc = cyc;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++;
    if (cordic_rst !== 1'b1) begin n_bad++; $display("FAIL reset_cordic_rst: got %b want 1", cordic_rst); end
    n_cmp++;
    if ({req_ready, resp_valid, resp_id, resp_sin, resp_cos, resp_err, busy, cordic_valid_in, cordic_angle} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b id=%0d sin=%h cos=%h err=%b busy=%b vin=%b ang=%h want all 0",
               req_ready, resp_valid, resp_id, resp_sin, resp_cos, resp_err, busy, cordic_valid_in, cordic_angle);
    end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cordic_rst, busy} !== 2'b00) begin n_bad++; $display("FAIL reset_release: got rst/busy=%b want 00", {cordic_rst, busy}); end
  endtask

  task automatic test_single();
    logic [3:0] r, rv; exp_t obs, ex; int t, rc, dc; bit ok;
    lat = 20; hang = 1'b0;
    req_angle[31:0] = ANG[1]; req_valid = 4'b0001;
    exp_q.push_back({2'd0, SIN[1], COS[1], 1'b0});
    wait_ready(r, t, ok);
    n_cmp++;
    if (r !== 4'b0001) begin n_bad++; $display("FAIL single_ready: got %b want 0001", r); end
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk); // T+1
    n_cmp++;
    if ({cordic_rst, busy, cordic_valid_in} !== 3'b110) begin
      n_bad++; $display("FAIL single_crst: got rst/busy/vin=%b want 110", {cordic_rst, busy, cordic_valid_in});
    end
    @(negedge clk); // T+2
    n_cmp++;
    if ({cordic_rst, cordic_valid_in, cordic_angle} !== {2'b01, ANG[1]}) begin
      n_bad++; $display("FAIL single_launch: got rst/vin=%b ang=%h want 01 %h", {cordic_rst, cordic_valid_in}, cordic_angle, ANG[1]);
    end
    @(negedge clk); // T+3
    n_cmp++;
    if (cordic_valid_in !== 1'b0) begin n_bad++; $display("FAIL single_vin_pulse: got %b want 0", cordic_valid_in); end
    wait_resp(rv, obs, rc, dc, ok);
    ex = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++;
    if (rv !== 4'b0001) begin n_bad++; $display("FAIL single_resp_valid: got %b want 0001", rv); end
    n_cmp++;
    if (obs !== ex) begin n_bad++; $display("FAIL single_resp: got %h want %h", obs, ex); end
    n_cmp++;
    if (rc - dc !== 1) begin n_bad++; $display("FAIL single_latency: got done->resp %0d want 1", rc - dc); end
    @(negedge clk);
    n_cmp++;
    if ({resp_valid, busy, resp_sin, resp_cos} !== {4'b0, 1'b0, SIN[1], COS[1]}) begin
      n_bad++; $display("FAIL single_hold: got rv=%b busy=%b sin=%h cos=%h want 0 0 %h %h", resp_valid, busy, resp_sin, resp_cos, SIN[1], COS[1]);
    end
  endtask

  task automatic test_all4();
    logic [3:0] r, rv, eg; exp_t obs, ex; int t, rc, dc; bit ok;
    rst = 1'b1; @(negedge clk); @(negedge clk); rst = 1'b0;
    lat = 6;
    for (int i = 0; i < 4; i++) req_angle[32*i +: 32] = ANG[i];
    for (int k = 0; k < 5; k++) exp_q.push_back({2'(k % 4), SIN[k % 4], COS[k % 4], 1'b0});
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      wait_ready(r, t, ok);
      n_cmp++;
      if (r !== eg) begin n_bad++; $display("FAIL all4_grant%0d: got %b want %b", k, r, eg); end
      if (k == 4) begin @(posedge clk); #1; req_valid = '0; end
      wait_resp(rv, obs, rc, dc, ok);
      ex = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      n_cmp++;
      if (rv !== eg || obs !== ex) begin
        n_bad++; $display("FAIL all4_resp%0d: got rv=%b %h want rv=%b %h", k, rv, obs, eg, ex);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] r, rv; exp_t obs, ex; int t, t2, rc, dc; bit ok;
    lat = 3;
    req_angle[31:0] = ANG[0];
    exp_q.push_back({2'd0, SIN[0], COS[0], 1'b0});
    exp_q.push_back({2'd0, SIN[0], COS[0], 1'b0});
    req_valid = 4'b0001;
    wait_ready(r, t, ok);
    n_cmp++;
    if (r !== 4'b0001) begin n_bad++; $display("FAIL b2b_ready1: got %b want 0001", r); end
    wait_resp(rv, obs, rc, dc, ok);
    ex = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++;
    if (rv !== 4'b0001 || obs !== ex) begin n_bad++; $display("FAIL b2b_resp1: got rv=%b %h want 0001 %h", rv, obs, ex); end
    wait_ready(r, t2, ok);
    n_cmp++;
    if (r !== 4'b0001 || t2 - dc !== 2) begin
      n_bad++; $display("FAIL b2b_reaccept: got rdy=%b done->accept %0d want 0001 2", r, t2 - dc);
    end
    @(posedge clk); #1; req_valid = '0;
    wait_resp(rv, obs, rc, dc, ok);
    ex = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++;
    if (rv !== 4'b0001 || obs !== ex) begin n_bad++; $display("FAIL b2b_resp2: got rv=%b %h want 0001 %h", rv, obs, ex); end
  endtask

  task automatic test_wrap();
    logic [3:0] r, rv; exp_t obs, ex; int t, rc, dc; bit ok;
    lat = 4;
    // serve requester 2 so the pointer lands on 3
    req_angle[64 +: 32] = ANG[2];
    exp_q.push_back({2'd2, SIN[2], COS[2], 1'b0});
    req_valid = 4'b0100;
    wait_ready(r, t, ok);
    @(posedge clk); #1; req_valid = '0;
    wait_resp(rv, obs, rc, dc, ok);
    ex = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++;
    if (rv !== 4'b0100 || obs !== ex) begin n_bad++; $display("FAIL wrap_setup: got rv=%b %h want 0100 %h", rv, obs, ex); end
    req_angle[31:0] = ANG[3];
    exp_q.push_back({2'd0, SIN[3], COS[3], 1'b0});
    exp_q.push_back({2'd2, SIN[2], COS[2], 1'b0});
    @(negedge clk);
    req_valid = 4'b0101;
    wait_ready(r, t, ok);
    n_cmp++;
    if (r !== 4'b0001) begin n_bad++; $display("FAIL wrap_grant0: got %b want 0001", r); end
    @(posedge clk); #1; req_valid = 4'b0100;
    wait_resp(rv, obs, rc, dc, ok);
    ex = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++;
    if (rv !== 4'b0001 || obs !== ex) begin n_bad++; $display("FAIL wrap_resp0: got rv=%b %h want 0001 %h", rv, obs, ex); end
    wait_ready(r, t, ok);
    n_cmp++;
    if (r !== 4'b0100) begin n_bad++; $display("FAIL wrap_grant2: got %b want 0100", r); end
    @(posedge clk); #1; req_valid = '0;
    wait_resp(rv, obs, rc, dc, ok);
    ex = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++;
    if (rv !== 4'b0100 || obs !== ex) begin n_bad++; $display("FAIL wrap_resp2: got rv=%b %h want 0100 %h", rv, obs, ex); end
  endtask

  task automatic test_rst_mid();
    logic [3:0] r, rv; exp_t obs, ex; int t, rc, dc, seen; bit ok;
    lat = 20;
    // pointer is 3 here; abort an operation for requester 3
    req_angle[96 +: 32] = ANG[3];
    @(negedge clk);
    req_valid = 4'b1000;
    wait_ready(r, t, ok);
    n_cmp++;
    if (r !== 4'b1000) begin n_bad++; $display("FAIL rstmid_grant3: got %b want 1000", r); end
    @(posedge clk); #1; req_valid = '0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (cordic_rst !== 1'b1) begin n_bad++; $display("FAIL rstmid_cordic_rst: got %b want 1", cordic_rst); end
    @(negedge clk);
    n_cmp++;
    if ({cordic_rst, busy, resp_valid} !== {1'b1, 1'b0, 4'b0}) begin
      n_bad++; $display("FAIL rstmid_in_reset: got rst=%b busy=%b rv=%b want 1 0 0000", cordic_rst, busy, resp_valid);
    end
    rst = 1'b0;
    seen = 0;
    repeat (40) begin @(negedge clk); if (resp_valid !== 4'b0) seen++; end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL rstmid_no_resp: got %0d strobes want 0", seen); end
    // pointer back at 0: requester 2 wins over 3
    req_angle[64 +: 32] = ANG[1];
    exp_q.push_back({2'd2, SIN[1], COS[1], 1'b0});
    req_valid = 4'b1100;
    wait_ready(r, t, ok);
    n_cmp++;
    if (r !== 4'b0100) begin n_bad++; $display("FAIL rstmid_ptr0: got %b want 0100", r); end
    @(posedge clk); #1; req_valid = '0;
    wait_resp(rv, obs, rc, dc, ok);
    ex = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++;
    if (rv !== 4'b0100 || obs !== ex) begin n_bad++; $display("FAIL rstmid_resp: got rv=%b %h want 0100 %h", rv, obs, ex); end
  endtask

  task automatic test_done_inject();
    logic [3:0] r, rv; exp_t obs, ex; int t, rc, dc, early; bit ok;
    lat = 10;
    req_angle[32 +: 32] = ANG[2];
    exp_q.push_back({2'd1, SIN[2], COS[2], 1'b0});
    @(negedge clk);
    req_valid = 4'b0010;
    wait_ready(r, t, ok);
    n_cmp++;
    if (r !== 4'b0010) begin n_bad++; $display("FAIL inject_grant: got %b want 0010", r); end
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk); inj_done = 1'b1;   // T+1, CRST
    early = 0;
    @(negedge clk); if (resp_valid !== 4'b0) early++;  // T+2, LAUNCH
    @(negedge clk); if (resp_valid !== 4'b0) early++;  // T+3
    inj_done = 1'b0;
    n_cmp++;
    if (early !== 0) begin n_bad++; $display("FAIL inject_early_resp: got %0d strobes want 0", early); end
    wait_resp(rv, obs, rc, dc, ok);
    ex = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++;
    if (rv !== 4'b0010 || obs !== ex) begin n_bad++; $display("FAIL inject_resp: got rv=%b %h want 0010 %h", rv, obs, ex); end
    n_cmp++;
    if (rc - dc !== 1 || dc < t + 10) begin
      n_bad++; $display("FAIL inject_timing: got done@%0d resp@%0d accept@%0d want real done after accept+10", dc, rc, t);
    end
  endtask

`ifdef CORDIC_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] r, rv; exp_t obs, ex; int t, rc, dc; bit ok;
    hang = 1'b1;
    req_angle[31:0] = ANG[1];
    exp_q.push_back({2'd0, 32'h7FC00000, 32'h7FC00000, 1'b1});
    @(negedge clk);
    req_valid = 4'b0001;
    wait_ready(r, t, ok);
    @(posedge clk); #1; req_valid = '0;
    wait_resp(rv, obs, rc, dc, ok);
    ex = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++;
    if (rv !== 4'b0001 || obs !== ex) begin n_bad++; $display("FAIL timeout_resp: got rv=%b %h want 0001 %h", rv, obs, ex); end
    n_cmp++;
    if (rc - (t + 3) !== 17) begin n_bad++; $display("FAIL timeout_cycles: got %0d want 17", rc - (t + 3)); end
    // done on the expiry cycle wins
    exp_q.push_back({2'd0, SIN[1], COS[1], 1'b0});
    @(negedge clk);
    req_valid = 4'b0001;
    wait_ready(r, t, ok);
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (resp_err !== 1'b0) begin n_bad++; $display("FAIL timeout_err_clear: got %b want 0", resp_err); end
    while (cyc < t + 19) @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    wait_resp(rv, obs, rc, dc, ok);
    rc = (resp_valid !== 4'b0 && !ok) ? cyc : rc;
    ex = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++;
    if (rv !== 4'b0001 || obs !== ex || rc !== t + 20) begin
      n_bad++; $display("FAIL timeout_done_wins: got rv=%b %h @%0d want 0001 %h @%0d", rv, obs, rc, ex, t + 20);
    end
    hang = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all4();
    test_back_to_back();
    test_wrap();
    test_rst_mid();
    test_done_inject();
`ifdef CORDIC_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
